reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-dependency scoreboard for the 5-stage pipeline. It is the producer/writer side of the hazard-detection path. It records destination registers when instructions leave ID with write-back enabled, and clears them when write-back completes. The ID stage queries it with its source registers and gets one stall signal. It replaces per-stage destination comparisons with per-register pending counters, so any pipeline depth and multi-cycle memory stalls are handled without extra compare ports.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero
- REG_W, 5, register index width
- CNT_W, 2, per-register pending counter width (max 3 in-flight writes per register)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- src1  in  REG_W  ID first source register
- src2  in  REG_W  ID second source register
- is_two_source  in  1  src2 is a real operand
- issue_valid  in  1  instruction in ID wants to advance to EX
- issue_wb_en  in  1  that instruction writes a register
- issue_dst  in  REG_W  its destination register
- wb_en  in  1  write-back stage commits a register write this cycle
- wb_dst  in  REG_W  committed destination
- hazard_detected  out  1  ID must stall; issue is not accepted
- inflight  out  7  total pending writes across all registers
- sb_err  out  1  sticky protocol-error flag

## Operation
- Each register r in 1..NUM_REGS-1 has a counter cnt[r] of width CNT_W. Register 0 never counts and is never a hazard.
- hazard_detected is combinational and asserts if any of the following holds:
  - src1 != 0 and cnt[src1] != 0
  - is_two_source, src2 != 0, and cnt[src2] != 0
  - issue_valid, issue_wb_en, issue_dst != 0, and cnt[issue_dst] is saturated (all ones). This is a WAW-overflow stall.
- Issue accept: accept = issue_valid & ~hazard_detected & issue_wb_en & (issue_dst != 0). On accept, cnt[issue_dst] increments.
- Retire: when wb_en & wb_dst != 0 and cnt[wb_dst] != 0, cnt[wb_dst] decrements.
- Retire with cnt[wb_dst] == 0: the counter stays 0 and sb_err sets. It remains set until reset.
- Accept and retire to the same register in the same cycle: the counter is unchanged.
- Accept and retire to different registers in the same cycle: both update independently.
- inflight is the registered sum of all counters. It is updated with the same deltas: +1 on accept, −1 on a valid retire.
- wb_en to register 0 is ignored, with no error.
- issue_wb_en=0 instructions never change state. They can still be stalled by source hazards.

## Timing
- Reset: on a rising edge with rst_n=0, all counters go to 0, inflight goes to 0, and sb_err goes to 0. Accept and retire in that cycle are ignored. hazard_detected is 0 during and after reset, because it is derived from zero counters.
- Reset mid-operation discards all pending state. The pipeline is flushed by the same reset.
- Latency:
  - An accept at edge N makes the register pending for queries in cycle N+1 onward.
  - A retire at edge M clears it for queries in cycle M+1. The same-cycle bypass is covered under Configuration.
- hazard_detected has zero-cycle, combinational dependence on src1/src2/is_two_source/issue_*.
- The counter at max value plus a retire in the same cycle: the WAW stall still asserts that cycle, because it is based on the current count.

## Configuration
- SB_WB_BYPASS_EN defined: the source checks treat register s as not pending when wb_en & wb_dst == s & cnt[s] == 1. The register file writes in the first half-cycle, so the reader gets the new value and stalls one cycle less.
- SB_WB_BYPASS_EN undefined: source checks use cnt only. A register retiring this cycle still stalls the reader until the next cycle.
- The WAW saturation check is never bypassed.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with wb_en=1, wb_dst=5 -> hazard_detected=0, inflight=0, sb_err=0.
- RAW: accept issue_dst=7 at edge 1, then src1=7 in cycle 2 -> hazard_detected=1. Retire wb_dst=7 at edge 4 -> hazard_detected=0 from cycle 5. With SB_WB_BYPASS_EN, it is 0 already in cycle 4.
- Two-source: cnt[9]=1, src1=3, src2=9 -> is_two_source=0 gives hazard 0; is_two_source=1 gives hazard 1.
- Saturation: three accepts to r4 (cnt=3) with src1/src2 non-pending, then issue_dst=4 -> hazard_detected=1, no accept, inflight stays 3.
- Simultaneous: cnt[6]=1, accept r6 plus retire r6 on the same edge -> cnt[6]=1, inflight unchanged.
- Error: retire wb_dst=12 with cnt[12]=0 -> sb_err=1 the next cycle and it holds. Retire wb_dst=0 -> no error. Accept issue_dst=0 -> inflight unchanged.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters for ID hazard stalls; hazard is combinational, counts update next edge.
// Backpressure: hazard_detected stalls ID and blocks the accept; optional SB_WB_BYPASS_EN clears sources retiring this cycle.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             is_two_source,
    input  logic             issue_valid,
    input  logic             issue_wb_en,
    input  logic [REG_W-1:0] issue_dst,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_dst,
    output logic             hazard_detected,
    output logic [6:0]       inflight,
    output logic             sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [6:0]       inflight_q, inflight_d;
    logic             sb_err_q, sb_err_d;

    logic src1_haz, src2_haz, waw_haz;
    logic accept, retire_ok, retire_err;
    logic [CNT_W-1:0] wb_cnt, dst_cnt;

    // Register 0 and indices beyond NUM_REGS never hold a pending write.
    function automatic logic [CNT_W-1:0] cnt_at(input logic [REG_W-1:0] r);
        if (r == '0 || int'(r) >= NUM_REGS) begin
            return '0;
        end
        return cnt_q[r];
    endfunction

    function automatic logic src_pending(input logic [REG_W-1:0] r);
        logic pend;
        pend = (cnt_at(r) != '0);
`ifdef SB_WB_BYPASS_EN
        // The register file writes early in the cycle, so the last outstanding
        // write landing now already satisfies the reader.
        if (wb_en && wb_dst == r && cnt_at(r) == CNT_ONE) begin
            pend = 1'b0;
        end
`endif
        return pend;
    endfunction

    always_comb begin
        src1_haz        = src_pending(src1);
        src2_haz        = is_two_source && src_pending(src2);
        dst_cnt         = cnt_at(issue_dst);
        waw_haz         = issue_valid && issue_wb_en && (issue_dst != '0) && (dst_cnt == CNT_MAX);
        hazard_detected = src1_haz || src2_haz || waw_haz;
    end

    always_comb begin
        wb_cnt     = cnt_at(wb_dst);
        accept     = issue_valid && !hazard_detected && issue_wb_en && (issue_dst != '0)
                     && (int'(issue_dst) < NUM_REGS);
        retire_ok  = wb_en && (wb_dst != '0) && (wb_cnt != '0);
        retire_err = wb_en && (wb_dst != '0) && (wb_cnt == '0);
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            case ({accept && (issue_dst == REG_W'(r)), retire_ok && (wb_dst == REG_W'(r))})
                2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
                2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, retire_ok})
            2'b10:   inflight_d = inflight_q + 7'd1;
            2'b01:   inflight_d = inflight_q - 7'd1;
            default: inflight_d = inflight_q;
        endcase
        sb_err_d = sb_err_q || retire_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            inflight_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            inflight_q <= inflight_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign inflight = inflight_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic against a per-register count model.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] src1, src2, issue_dst, wb_dst;
    logic       is_two_source, issue_valid, issue_wb_en, wb_en;
    logic       hazard_detected, sb_err;
    logic [6:0] inflight;

    int checks = 0;
    int errors = 0;

    int m_cnt [32];
    int m_inflight;
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .is_two_source(is_two_source),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dst(issue_dst),
        .wb_en(wb_en), .wb_dst(wb_dst), .hazard_detected(hazard_detected),
        .inflight(inflight), .sb_err(sb_err)
    );

    function automatic bit m_src_busy(input int r);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef SB_WB_BYPASS_EN
        if (wb_en && int'(wb_dst) == r && m_cnt[r] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = m_src_busy(int'(src1));
        if (is_two_source && m_src_busy(int'(src2))) h = 1'b1;
        if (issue_valid && issue_wb_en && issue_dst != 0 && m_cnt[issue_dst] == 3) h = 1'b1;
        return h;
    endfunction

    // Advance one edge, applying the rules to the model with the inputs present at that edge.
    task automatic tick();
        bit acc;
        int wd;
        acc = issue_valid && !m_hazard() && issue_wb_en && issue_dst != 0;
        wd  = int'(wb_dst);
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_inflight = 0;
            m_err = 1'b0;
        end else begin
            if (wb_en && wd != 0) begin
                if (m_cnt[wd] == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_cnt[wd]--;
                    m_inflight--;
                end
            end
            if (acc) begin
                m_cnt[issue_dst]++;
                m_inflight++;
            end
        end
        #1;
    endtask

    task automatic idle();
        src1 = 0; src2 = 0; is_two_source = 0;
        issue_valid = 0; issue_wb_en = 0; issue_dst = 0;
        wb_en = 0; wb_dst = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic issue(input int d);
        issue_valid = 1; issue_wb_en = 1; issue_dst = 5'(d);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        wb_en = 1; wb_dst = 5;
        tick();
        tick();
        checks++;
        if (hazard_detected !== 1'b0 || inflight !== 7'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: hazard=%b inflight=%0d sb_err=%b, want 0/0/0", hazard_detected, inflight, sb_err);
        end
        rst_n = 1;
        idle();
        tick();
        checks++;
        if (sb_err !== 1'b0 || inflight !== 7'd0) begin
            errors++;
            $display("FAIL reset_release: inflight=%0d sb_err=%b, want 0/0", inflight, sb_err);
        end
    endtask

    task automatic test_raw();
        do_reset();
        issue(7);
        tick();
        idle();
        src1 = 7;
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL raw_pending: hazard=%b want 1", hazard_detected);
        end
        tick();
        wb_en = 1; wb_dst = 7;
        #1;
        checks++;
`ifdef SB_WB_BYPASS_EN
        if (hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL raw_retire_cycle: hazard=%b want 0", hazard_detected);
        end
`else
        if (hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL raw_retire_cycle: hazard=%b want 1", hazard_detected);
        end
`endif
        tick();
        wb_en = 0;
        #1;
        checks++;
        if (hazard_detected !== 1'b0 || inflight !== 7'd0) begin
            errors++;
            $display("FAIL raw_cleared: hazard=%b inflight=%0d want 0/0", hazard_detected, inflight);
        end
    endtask

    task automatic test_two_source();
        do_reset();
        issue(9);
        tick();
        idle();
        src1 = 3; src2 = 9; is_two_source = 0;
        #1;
        checks++;
        if (hazard_detected !== 1'b0) begin
            errors++;
            $display("FAIL two_src_off: hazard=%b want 0", hazard_detected);
        end
        is_two_source = 1;
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL two_src_on: hazard=%b want 1", hazard_detected);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        src1 = 1; src2 = 2; is_two_source = 1;
        for (int i = 0; i < 3; i++) begin
            issue(4);
            tick();
        end
        #1;
        checks++;
        if (hazard_detected !== 1'b1 || inflight !== 7'd3) begin
            errors++;
            $display("FAIL sat_stall: hazard=%b inflight=%0d want 1/3", hazard_detected, inflight);
        end
        // Retiring a write to r4 this cycle must not lift the overflow stall.
        wb_en = 1; wb_dst = 4;
        #1;
        checks++;
        if (hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL sat_with_retire: hazard=%b want 1", hazard_detected);
        end
        wb_en = 0;
        tick();
        checks++;
        if (inflight !== 7'd3) begin
            errors++;
            $display("FAIL sat_no_accept: inflight=%0d want 3", inflight);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue(6);
        tick();
        wb_en = 1; wb_dst = 6;
        tick();
        idle();
        src1 = 6;
        #1;
        checks++;
        if (inflight !== 7'd1 || hazard_detected !== 1'b1) begin
            errors++;
            $display("FAIL simul_same: inflight=%0d hazard=%b want 1/1", inflight, hazard_detected);
        end
        issue(8);
        src1 = 0;
        wb_en = 1; wb_dst = 6;
        tick();
        idle();
        src1 = 8;
        #1;
        checks++;
        if (inflight !== 7'd1 || hazard_detected !== 1'b1 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_diff: inflight=%0d hazard=%b err=%b want 1/1/0", inflight, hazard_detected, sb_err);
        end
    endtask

    task automatic test_error();
        do_reset();
        wb_en = 1; wb_dst = 0;
        tick();
        idle();
        issue(0);
        tick();
        idle();
        checks++;
        if (sb_err !== 1'b0 || inflight !== 7'd0) begin
            errors++;
            $display("FAIL err_r0: sb_err=%b inflight=%0d want 0/0", sb_err, inflight);
        end
        wb_en = 1; wb_dst = 12;
        tick();
        idle();
        checks++;
        if (sb_err !== 1'b1 || inflight !== 7'd0) begin
            errors++;
            $display("FAIL err_set: sb_err=%b inflight=%0d want 1/0", sb_err, inflight);
        end
        tick();
        tick();
        checks++;
        if (sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: sb_err=%b want 1", sb_err);
        end
    endtask

    task automatic test_random();
        bit exp_h;
        int sum;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            src1          = 5'($urandom_range(0, 7));
            src2          = 5'($urandom_range(0, 7));
            is_two_source = 1'($urandom);
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_wb_en   = ($urandom_range(0, 4) != 0);
            issue_dst     = 5'($urandom_range(0, 7));
            wb_en         = 1'($urandom);
            wb_dst        = 5'($urandom_range(0, 7));
            #1;
            exp_h = m_hazard();
            checks++;
            if (hazard_detected !== exp_h) begin
                errors++;
                $display("FAIL rand_hazard[%0d]: got %b want %b", n, hazard_detected, exp_h);
            end
            tick();
            sum = 0;
            foreach (m_cnt[i]) sum += m_cnt[i];
            checks++;
            if (inflight !== 7'(sum) || sb_err !== m_err) begin
                errors++;
                $display("FAIL rand_state[%0d]: inflight=%0d err=%b want %0d/%b", n, inflight, sb_err, sum, m_err);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_inflight = 0;
        m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_raw();
        test_two_source();
        test_saturation();
        test_simultaneous();
        test_error();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
